// File: rtl/vram_scheduler_pkg.sv
// Shared video constants and scheduler state encoding.
// Holds the default line geometry (also used by the line-buffer reader)
// and the VRAM scheduler FSM state type.
package video_pkg;

  localparam int DEF_ADDR_WIDTH  = 15;
  localparam int DEF_LINE_PIXELS = 160;
  localparam int DEF_LB_WIDTH    = 8;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FETCH     = 3'd1,
    ST_DRAIN     = 3'd2,
    ST_CPU_ISSUE = 3'd3,
    ST_CPU_DONE  = 3'd4
  } sched_state_e;

endpackage

// File: rtl/vram_scheduler_if.sv
// Bus bundle between the VRAM scheduler and its environment.
// Groups the scanout line request, the line-buffer write port, the VRAM
// port and the CPU req/ack port.
//   slave  : the scheduler side (drives status, lb_*, ram_*, cpu_ack/rdata)
//   master : the environment side (drives line_req/base, ram_rdata, cpu_*)
interface vram_scheduler_if #(
  parameter int ADDR_WIDTH = video_pkg::DEF_ADDR_WIDTH,
  parameter int LB_WIDTH   = video_pkg::DEF_LB_WIDTH
) ();

  // scanout request / status
  logic                  line_req;
  logic [ADDR_WIDTH-1:0] line_base;
  logic                  fetch_busy;
  logic                  fetch_done;
  logic                  overrun;
  // line-buffer write port
  logic                  lb_we;
  logic [LB_WIDTH-1:0]   lb_addr;
  logic [7:0]            lb_wdata;
  // single-port VRAM
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic                  ram_we;
  logic [7:0]            ram_wdata;
  logic [7:0]            ram_rdata;
  // CPU access port
  logic                  cpu_req;
  logic                  cpu_we;
  logic [ADDR_WIDTH-1:0] cpu_addr;
  logic [7:0]            cpu_wdata;
  logic                  cpu_ack;
  logic [7:0]            cpu_rdata;

  modport slave (
    input  line_req, line_base, ram_rdata, cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output fetch_busy, fetch_done, overrun, lb_we, lb_addr, lb_wdata,
           ram_addr, ram_we, ram_wdata, cpu_ack, cpu_rdata
  );

  modport master (
    output line_req, line_base, ram_rdata, cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  fetch_busy, fetch_done, overrun, lb_we, lb_addr, lb_wdata,
           ram_addr, ram_we, ram_wdata, cpu_ack, cpu_rdata
  );

endinterface

// File: rtl/vram_scheduler.sv
// VRAM scheduler: shares a single-port video RAM between scanout line
// fetches and CPU read/write accesses. A line fetch streams LINE_PIXELS
// bytes from line_base upward into the line buffer; CPU accesses fill the
// remaining cycles. A line request during a running fetch is dropped and
// flags a sticky overrun.
// Ports:
//   clk   : pixel clock
//   reset : asynchronous, active-high
//   bus   : vram_scheduler_if.slave (line request/status, lb_*, ram_*, cpu_*)
module vram_scheduler
  import video_pkg::*;
#(
  parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int LINE_PIXELS = DEF_LINE_PIXELS,
  parameter int LB_WIDTH    = DEF_LB_WIDTH
) (
  input logic             clk,
  input logic             reset,
  vram_scheduler_if.slave bus
);

  // one extra bit so LINE_PIXELS = 2^LB_WIDTH does not wrap the counter
  localparam int               CNT_W    = LB_WIDTH + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LINE_PIXELS - 1);

  sched_state_e          state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic                  pending_q, pending_d;
  logic                  overrun_q, overrun_d;
  logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
  logic                  ram_we_q, ram_we_d;
  logic [7:0]            ram_wdata_q, ram_wdata_d;
  logic                  lb_we_q, lb_we_d;
  logic [LB_WIDTH-1:0]   lb_addr_q, lb_addr_d;
  logic                  fetch_busy_q, fetch_busy_d;
  logic                  fetch_done_q, fetch_done_d;
  logic                  cpu_ack_q, cpu_ack_d;
  logic                  cpu_rd_q, cpu_rd_d;

  logic                  start_fetch;
  logic [ADDR_WIDTH-1:0] fetch_base;

  // Every *_d below is the value the output takes in the NEXT cycle, so all
  // ram_*/lb_* controls come straight from flops.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    base_d       = base_q;
    pending_d    = pending_q;
    overrun_d    = overrun_q;
    ram_addr_d   = ram_addr_q;
    ram_we_d     = 1'b0;
    ram_wdata_d  = ram_wdata_q;
    lb_we_d      = 1'b0;
    lb_addr_d    = lb_addr_q;
    fetch_busy_d = 1'b0;
    fetch_done_d = 1'b0;
    cpu_ack_d    = 1'b0;
    cpu_rd_d     = cpu_rd_q;
    start_fetch  = 1'b0;
    fetch_base   = base_q;

    if (bus.line_req) begin
      if (state_q == ST_FETCH || state_q == ST_DRAIN) begin
        overrun_d = 1'b1;
      end else begin
        pending_d = 1'b1;
        base_d    = bus.line_base;
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (pending_q || bus.line_req) begin
          start_fetch = 1'b1;
          // a request arriving this cycle supersedes an older pending base
          if (bus.line_req) fetch_base = bus.line_base;
        end else if (bus.cpu_req) begin
          state_d     = ST_CPU_ISSUE;
          ram_addr_d  = bus.cpu_addr;
          ram_we_d    = bus.cpu_we;
          ram_wdata_d = bus.cpu_wdata;
          cpu_rd_d    = ~bus.cpu_we;
        end
      end
      ST_FETCH: begin
        // data for address cnt returns next cycle, written to lb slot cnt
        fetch_busy_d = 1'b1;
        lb_we_d      = 1'b1;
        lb_addr_d    = cnt_q[LB_WIDTH-1:0];
        if (cnt_q == CNT_LAST) begin
          state_d      = ST_DRAIN;
          fetch_done_d = 1'b1;
        end else begin
          cnt_d      = cnt_q + CNT_W'(1);
          ram_addr_d = base_q + ADDR_WIDTH'(cnt_q) + ADDR_WIDTH'(1);
        end
      end
      ST_DRAIN: begin
        if (pending_q) start_fetch = 1'b1;
        else           state_d     = ST_IDLE;
      end
      ST_CPU_ISSUE: begin
        state_d   = ST_CPU_DONE;
        cpu_ack_d = 1'b1;
      end
      ST_CPU_DONE: begin
        if (pending_q) start_fetch = 1'b1;
        else           state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (start_fetch) begin
      state_d      = ST_FETCH;
      cnt_d        = '0;
      pending_d    = 1'b0;
      base_d       = fetch_base;
      ram_addr_d   = fetch_base;
      fetch_busy_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      base_q       <= '0;
      pending_q    <= 1'b0;
      overrun_q    <= 1'b0;
      ram_addr_q   <= '0;
      ram_we_q     <= 1'b0;
      ram_wdata_q  <= '0;
      lb_we_q      <= 1'b0;
      lb_addr_q    <= '0;
      fetch_busy_q <= 1'b0;
      fetch_done_q <= 1'b0;
      cpu_ack_q    <= 1'b0;
      cpu_rd_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      base_q       <= base_d;
      pending_q    <= pending_d;
      overrun_q    <= overrun_d;
      ram_addr_q   <= ram_addr_d;
      ram_we_q     <= ram_we_d;
      ram_wdata_q  <= ram_wdata_d;
      lb_we_q      <= lb_we_d;
      lb_addr_q    <= lb_addr_d;
      fetch_busy_q <= fetch_busy_d;
      fetch_done_q <= fetch_done_d;
      cpu_ack_q    <= cpu_ack_d;
      cpu_rd_q     <= cpu_rd_d;
    end
  end

  assign bus.fetch_busy = fetch_busy_q;
  assign bus.fetch_done = fetch_done_q;
  assign bus.overrun    = overrun_q;
  assign bus.lb_we      = lb_we_q;
  assign bus.lb_addr    = lb_addr_q;
  assign bus.ram_addr   = ram_addr_q;
  assign bus.ram_we     = ram_we_q;
  assign bus.ram_wdata  = ram_wdata_q;
  assign bus.cpu_ack    = cpu_ack_q;

  // ram_rdata is the RAM's own read register; it is forwarded unregistered
  // so the byte lands in the same cycle as its lb_we/cpu_ack, and gated so
  // these outputs read 0 outside their valid cycles (including reset).
  assign bus.lb_wdata  = lb_we_q ? bus.ram_rdata : 8'h00;
  assign bus.cpu_rdata = (cpu_ack_q && cpu_rd_q) ? bus.ram_rdata : 8'h00;

endmodule

// File: tb/tb_vram_scheduler.sv
// Testbench for vram_scheduler: behavioural VRAM model plus a shadow copy
// of memory contents; fetch and CPU timelines are predicted from cycle
// offsets relative to the request.
module tb_vram_scheduler;
  import video_pkg::*;

  localparam int AW = 15;
  localparam int LW = 8;
  localparam int L  = 160;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  vram_scheduler_if #(.ADDR_WIDTH(AW), .LB_WIDTH(LW)) bus ();

  vram_scheduler #(.ADDR_WIDTH(AW), .LINE_PIXELS(L), .LB_WIDTH(LW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // single-port synchronous RAM, read-before-write, 1-cycle read latency
  logic [7:0] vram   [0:(1<<AW)-1];
  logic [7:0] shadow [0:(1<<AW)-1];
  logic [7:0] rdata_r;
  always @(posedge clk) begin
    rdata_r <= vram[bus.ram_addr];
    if (bus.ram_we) vram[bus.ram_addr] = bus.ram_wdata;
  end
  assign bus.ram_rdata = rdata_r;

  int vectors = 0;
  int errors  = 0;

  function automatic logic [AW-1:0] wrap(input int a);
    return AW'(a);
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus.line_req = 1'b0; bus.line_base = '0;
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
  endtask

  task automatic fill(input bit rnd);
    logic [7:0] v;
    for (int a = 0; a < (1 << AW); a++) begin
      v = rnd ? 8'($urandom) : a[7:0];
      vram[a] = v;
      shadow[a] = v;
    end
  endtask

  task automatic start_line(input logic [AW-1:0] base);
    tick();
    bus.line_req = 1'b1; bus.line_base = base;
    sample();
  endtask

  // Fetch timeline: j = cycles after the cycle in which the fetch was
  // accepted (line_req in IDLE, or the CPU_DONE cycle with a pending line).
  task automatic fetch_cycles(input logic [AW-1:0] base, input int first_j,
                              input int last_j, input int inj_j);
    logic          exp_busy, exp_lbwe;
    logic [AW-1:0] exp_addr;
    for (int j = first_j; j <= last_j; j++) begin
      tick();
      bus.line_req  = (j == inj_j);
      bus.line_base = ~base;
      sample();
      exp_busy = (j >= 1 && j <= L + 1);
      exp_lbwe = (j >= 2 && j <= L + 1);
      exp_addr = (j <= L) ? wrap(base + j - 1) : wrap(base + L - 1);
      vectors++;
      if (bus.fetch_busy !== exp_busy) begin
        errors++; $display("FAIL fetch_busy j=%0d got %b want %b", j, bus.fetch_busy, exp_busy);
      end
      vectors++;
      if (bus.ram_we !== 1'b0 || bus.ram_addr !== exp_addr) begin
        errors++; $display("FAIL fetch_ram j=%0d got we=%b addr=%h want we=0 addr=%h", j, bus.ram_we, bus.ram_addr, exp_addr);
      end
      vectors++;
      if (bus.lb_we !== exp_lbwe) begin
        errors++; $display("FAIL lb_we j=%0d got %b want %b", j, bus.lb_we, exp_lbwe);
      end
      if (exp_lbwe) begin
        vectors++;
        if (bus.lb_addr !== LW'(j - 2) || bus.lb_wdata !== shadow[wrap(base + j - 2)]) begin
          errors++; $display("FAIL lb_write j=%0d got addr=%0d data=%h want addr=%0d data=%h", j, bus.lb_addr, bus.lb_wdata, j - 2, shadow[wrap(base + j - 2)]);
        end
      end
      vectors++;
      if (bus.fetch_done !== (j == L + 1) || bus.cpu_ack !== 1'b0) begin
        errors++; $display("FAIL fetch_done j=%0d got done=%b ack=%b want done=%b ack=0", j, bus.fetch_done, bus.cpu_ack, (j == L + 1));
      end
    end
    bus.line_req = 1'b0;
  endtask

  task automatic cpu_access(input logic we, input logic [AW-1:0] addr, input logic [7:0] wdata);
    logic [7:0] exp_rd;
    tick();
    bus.cpu_req = 1'b1; bus.cpu_we = we; bus.cpu_addr = addr; bus.cpu_wdata = wdata;
    sample();
    vectors++;
    if (bus.cpu_ack !== 1'b0) begin errors++; $display("FAIL cpu_early_ack t0 got %b want 0", bus.cpu_ack); end
    tick(); sample();
    vectors++;
    if (bus.ram_we !== we || bus.ram_addr !== addr || bus.ram_wdata !== wdata || bus.cpu_ack !== 1'b0) begin
      errors++; $display("FAIL cpu_issue got we=%b addr=%h wd=%h ack=%b want we=%b addr=%h wd=%h ack=0",
                         bus.ram_we, bus.ram_addr, bus.ram_wdata, bus.cpu_ack, we, addr, wdata);
    end
    tick(); sample();
    exp_rd = we ? 8'h00 : shadow[addr];
    vectors++;
    if (bus.cpu_ack !== 1'b1 || bus.cpu_rdata !== exp_rd || bus.ram_we !== 1'b0) begin
      errors++; $display("FAIL cpu_ack got ack=%b rdata=%h we=%b want ack=1 rdata=%h we=0", bus.cpu_ack, bus.cpu_rdata, bus.ram_we, exp_rd);
    end
    if (we) shadow[addr] = wdata;
    tick(); bus.cpu_req = 1'b0; sample();
    vectors++;
    if (bus.cpu_ack !== 1'b0 || bus.ram_we !== 1'b0) begin
      errors++; $display("FAIL cpu_after got ack=%b we=%b want 0 0", bus.cpu_ack, bus.ram_we);
    end
  endtask

  task automatic test_reset();
    logic [52:0] outs;
    reset = 1'b1;
    idle_inputs();
    repeat (3) @(posedge clk);
    sample();
    outs = {bus.fetch_busy, bus.fetch_done, bus.overrun, bus.lb_we, bus.lb_addr, bus.lb_wdata,
            bus.ram_addr, bus.ram_we, bus.ram_wdata, bus.cpu_ack, bus.cpu_rdata};
    vectors++;
    if (outs !== '0) begin errors++; $display("FAIL reset_outputs got %h want 0", outs); end
    tick(); reset = 1'b0; sample();
    outs = {bus.fetch_busy, bus.fetch_done, bus.overrun, bus.lb_we, bus.lb_addr, bus.lb_wdata,
            bus.ram_addr, bus.ram_we, bus.ram_wdata, bus.cpu_ack, bus.cpu_rdata};
    vectors++;
    if (outs !== '0) begin errors++; $display("FAIL post_reset_idle got %h want 0", outs); end
  endtask

  task automatic test_fetch(input logic [AW-1:0] base);
    start_line(base);
    vectors++;
    if (bus.fetch_busy !== 1'b0) begin errors++; $display("FAIL fetch_busy_t0 got %b want 0", bus.fetch_busy); end
    fetch_cycles(base, 1, L + 2, -1);
  endtask

  task automatic test_random_fetch();
    for (int i = 0; i < 3; i++) test_fetch(AW'($urandom));
  endtask

  task automatic test_cpu_random();
    logic [AW-1:0] a;
    for (int i = 0; i < 6; i++) begin
      a = AW'($urandom);
      cpu_access(1'b1, a, 8'($urandom));
      cpu_access(1'b0, a, 8'($urandom));
      cpu_access(1'b0, AW'($urandom), 8'h00);
    end
  endtask

  task automatic test_collision();
    logic [AW-1:0] base, a;
    logic [7:0]    d;
    base = AW'($urandom); a = AW'($urandom); d = 8'($urandom);
    tick();
    bus.line_req = 1'b1; bus.line_base = base;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = a; bus.cpu_wdata = d;
    sample();
    fetch_cycles(base, 1, L + 2, -1);
    tick(); sample();
    vectors++;
    if (bus.ram_we !== 1'b1 || bus.ram_addr !== a || bus.cpu_ack !== 1'b0) begin
      errors++; $display("FAIL collision_issue got we=%b addr=%h ack=%b want 1 %h 0", bus.ram_we, bus.ram_addr, bus.cpu_ack, a);
    end
    tick(); sample();
    vectors++;
    if (bus.cpu_ack !== 1'b1) begin errors++; $display("FAIL collision_ack_164 got %b want 1", bus.cpu_ack); end
    shadow[a] = d;
    tick(); bus.cpu_req = 1'b0; sample();
    vectors++;
    if (bus.cpu_ack !== 1'b0) begin errors++; $display("FAIL collision_ack_after got %b want 0", bus.cpu_ack); end
  endtask

  task automatic test_back_to_back();
    logic [AW-1:0] base, a;
    base = AW'($urandom); a = AW'($urandom);
    tick();
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = a; bus.cpu_wdata = 8'h00;
    sample();
    tick(); bus.line_req = 1'b1; bus.line_base = base; sample();
    vectors++;
    if (bus.ram_we !== 1'b0 || bus.ram_addr !== a) begin
      errors++; $display("FAIL b2b_issue got we=%b addr=%h want 0 %h", bus.ram_we, bus.ram_addr, a);
    end
    tick(); bus.line_req = 1'b0; sample();
    vectors++;
    if (bus.cpu_ack !== 1'b1 || bus.cpu_rdata !== shadow[a] || bus.fetch_busy !== 1'b0) begin
      errors++; $display("FAIL b2b_ack got ack=%b rdata=%h busy=%b want 1 %h 0", bus.cpu_ack, bus.cpu_rdata, bus.fetch_busy, shadow[a]);
    end
    fetch_cycles(base, 1, L + 2, -1);
    tick(); sample();
    vectors++;
    if (bus.ram_addr !== a || bus.ram_we !== 1'b0 || bus.cpu_ack !== 1'b0) begin
      errors++; $display("FAIL b2b_reissue got addr=%h we=%b ack=%b want %h 0 0", bus.ram_addr, bus.ram_we, bus.cpu_ack, a);
    end
    tick(); sample();
    vectors++;
    if (bus.cpu_ack !== 1'b1 || bus.cpu_rdata !== shadow[a]) begin
      errors++; $display("FAIL b2b_reack got ack=%b rdata=%h want 1 %h", bus.cpu_ack, bus.cpu_rdata, shadow[a]);
    end
    tick(); bus.cpu_req = 1'b0; sample();
  endtask

  task automatic test_overrun();
    logic [AW-1:0] base, hold;
    base = AW'($urandom);
    vectors++;
    if (bus.overrun !== 1'b0) begin errors++; $display("FAIL overrun_before got %b want 0", bus.overrun); end
    start_line(base);
    fetch_cycles(base, 1, L + 2, 51);
    vectors++;
    if (bus.overrun !== 1'b1) begin errors++; $display("FAIL overrun_set got %b want 1", bus.overrun); end
    hold = wrap(base + L - 1);
    for (int k = 0; k < 3; k++) begin
      tick(); sample();
      vectors++;
      if (bus.fetch_busy !== 1'b0 || bus.ram_addr !== hold) begin
        errors++; $display("FAIL overrun_dropped got busy=%b addr=%h want 0 %h", bus.fetch_busy, bus.ram_addr, hold);
      end
    end
    cpu_access(1'b0, AW'($urandom), 8'h00);
    vectors++;
    if (bus.overrun !== 1'b1) begin errors++; $display("FAIL overrun_sticky got %b want 1", bus.overrun); end
  endtask

  task automatic test_reset_mid_fetch();
    logic [AW-1:0] base;
    logic [52:0]   outs;
    base = AW'($urandom);
    start_line(base);
    fetch_cycles(base, 1, 81, -1);
    #2 reset = 1'b1;
    #1;
    outs = {bus.fetch_busy, bus.fetch_done, bus.overrun, bus.lb_we, bus.lb_addr, bus.lb_wdata,
            bus.ram_addr, bus.ram_we, bus.ram_wdata, bus.cpu_ack, bus.cpu_rdata};
    vectors++;
    if (outs !== '0) begin errors++; $display("FAIL async_reset got %h want 0", outs); end
    for (int k = 0; k < 3; k++) begin
      tick(); sample();
      outs = {bus.fetch_busy, bus.fetch_done, bus.overrun, bus.lb_we, bus.lb_addr, bus.lb_wdata,
              bus.ram_addr, bus.ram_we, bus.ram_wdata, bus.cpu_ack, bus.cpu_rdata};
      vectors++;
      if (outs !== '0) begin errors++; $display("FAIL reset_hold got %h want 0", outs); end
    end
    tick(); reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      sample();
      vectors++;
      if (bus.fetch_busy !== 1'b0 || bus.fetch_done !== 1'b0) begin
        errors++; $display("FAIL reset_abandon got busy=%b done=%b want 0 0", bus.fetch_busy, bus.fetch_done);
      end
      tick();
    end
    test_fetch(AW'($urandom));
  endtask

  initial begin
    test_reset();
    fill(1'b0);
    test_fetch(15'h0100);
    test_fetch(15'h7FF0);
    cpu_access(1'b1, 15'h1234, 8'hA5);
    cpu_access(1'b0, 15'h1234, 8'h00);
    fill(1'b1);
    test_cpu_random();
    test_random_fetch();
    test_collision();
    test_back_to_back();
    test_overrun();
    test_reset_mid_fetch();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
